// File: rtl/sa_result_drain_if.sv
// Row-beat valid/ready bus carrying one PE row of results per transfer.
// The master presents beats and the slave accepts them.
interface sa_result_drain_if #(
    parameter int WIDTH = 8,
    parameter int HPE   = 4,
    parameter int IDXW  = 2
);
    logic                      OUT_VALID;
    logic                      OUT_READY;
    logic [2*WIDTH*HPE-1:0]    OUT_ROW;
    logic [IDXW-1:0]           OUT_IDX;
    logic                      OUT_LAST;

    modport master (
        output OUT_VALID,
        output OUT_ROW,
        output OUT_IDX,
        output OUT_LAST,
        input  OUT_READY
    );

    modport slave (
        input  OUT_VALID,
        input  OUT_ROW,
        input  OUT_IDX,
        input  OUT_LAST,
        output OUT_READY
    );
endinterface

// File: rtl/sa_result_drain.sv
// Snapshots the systolic-array result bus on CAP and streams it out one PE
// row per valid/ready beat, in row order.
module sa_result_drain #(
    parameter int WIDTH = 8,
    parameter int HPE   = 4,
    parameter int VPE   = 4,
    parameter int IDXW  = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [2*WIDTH*HPE*VPE-1:0] Y_IN,
    input  logic                       CAP,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       OVERRUN,
    sa_result_drain_if.master          out
);
    localparam int RW   = 2 * WIDTH;
    localparam int ROWW = RW * HPE;
    localparam int NRES = HPE * VPE;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [ROWW-1:0]   buf_q [VPE];
    logic [ROWW-1:0]   buf_d [VPE];
    logic [ROWW-1:0]   cap_rows [VPE];
    logic              last_row;
    logic              xfer;

    // Row 0, col 0 is the most significant slice of Y_IN; col 0 lands in the
    // least significant slice of a row beat.
    always_comb begin
        for (int j = 0; j < VPE; j++) begin
            cap_rows[j] = '0;
            for (int i = 0; i < HPE; i++) begin
                cap_rows[j][i*RW +: RW] = Y_IN[(NRES-(j*HPE+i))*RW-1 -: RW];
            end
        end
    end

    assign last_row = (idx_q == IDXW'(VPE - 1));
    assign xfer     = (state_q == S_STREAM) && out.OUT_READY;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        buf_d     = buf_q;
        case (state_q)
            S_IDLE: begin
                if (CAP) begin
                    buf_d   = cap_rows;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                // A capture while busy is dropped; the snapshot stays intact.
                if (CAP) begin
                    overrun_d = 1'b1;
                end
                if (xfer) begin
                    if (last_row) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values computed by the combinational block.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the snapshot buffer is deliberately left out of reset; it is only
    // observed after a capture has loaded it.
    always_ff @(posedge CLK) begin
        buf_q <= buf_d;
    end

    assign BUSY          = (state_q == S_STREAM);
    assign DONE          = done_q;
    assign OVERRUN       = overrun_q;
    assign out.OUT_VALID = (state_q == S_STREAM);
    assign out.OUT_IDX   = idx_q;
    assign out.OUT_LAST  = (state_q == S_STREAM) && last_row;
    assign out.OUT_ROW   = (state_q == S_STREAM) ? buf_q[idx_q] : '0;

endmodule
